// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response bundle shared by the core (master) and memory-side responder (slave).
interface sysbus_mem_responder_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
    logic                      bus_respack;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus responder: block-aligned 8-beat read/write bursts into a word array.
//   IDLE     | waiting for a request; captures address and tag
//   ADDR_ACK | one-cycle address acknowledge, decides read or write
//   RD_WAIT  | read latency countdown
//   RD_RESP  | returning read beats, advanced by respack
//   WR_DATA  | accepting write beats, reqack follows reqcyc
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int BEATS          = 8,
    parameter int READ_LATENCY   = 4
) (
    input logic                   clk,
    input logic                   reset,
    sysbus_mem_responder_if.slave bus
);
    localparam int AW      = $clog2(MEM_WORDS);
    localparam int BW      = $clog2(BEATS);
    localparam int KW      = AW - BW;
    localparam int BLK_LSB = 6;
    localparam int RD_BIT  = 12;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_ACK,
        RD_WAIT,
        RD_RESP,
        WR_DATA
    } state_t;

    state_t                   state, state_nxt;
    logic [KW-1:0]            blk, blk_nxt;
    logic [BUS_TAG_WIDTH-1:0] tag, tag_nxt;
    logic [BW-1:0]            beat, beat_nxt;
    logic [7:0]               lat_cnt, lat_cnt_nxt;
    logic                     ack_q;
    logic                     mem_we;
    logic [AW-1:0]            idx;

    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Upper address bits beyond the array simply drop off, giving the modulo wrap.
    assign idx = {blk, beat};

    always_comb begin
        state_nxt   = state;
        blk_nxt     = blk;
        tag_nxt     = tag;
        beat_nxt    = beat;
        lat_cnt_nxt = lat_cnt;
        mem_we      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.bus_reqcyc) begin
                    blk_nxt   = bus.bus_req[BLK_LSB +: KW];
                    tag_nxt   = bus.bus_reqtag;
                    state_nxt = ADDR_ACK;
                end
            end
            ADDR_ACK: begin
                beat_nxt = '0;
                if (tag[RD_BIT]) begin
                    lat_cnt_nxt = 8'(READ_LATENCY);
                    state_nxt   = RD_WAIT;
                end else begin
                    state_nxt = WR_DATA;
                end
            end
            RD_WAIT: begin
                if (lat_cnt != 8'd0) begin
                    lat_cnt_nxt = lat_cnt - 8'd1;
                end
                if (lat_cnt <= 8'd1) begin
                    state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                if (bus.bus_respack) begin
                    beat_nxt = beat + BW'(1);
                    if (beat == LAST_BEAT) begin
                        state_nxt = IDLE;
                    end
                end
            end
            WR_DATA: begin
                if (bus.bus_reqcyc) begin
                    mem_we   = 1'b1;
                    beat_nxt = beat + BW'(1);
                    if (beat == LAST_BEAT) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            blk     <= '0;
            tag     <= '0;
            beat    <= '0;
            lat_cnt <= '0;
            ack_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            blk     <= blk_nxt;
            tag     <= tag_nxt;
            beat    <= beat_nxt;
            lat_cnt <= lat_cnt_nxt;
            ack_q   <= (state_nxt == ADDR_ACK);
        end
    end

    // The array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= bus.bus_req;
        end
    end

    assign bus.bus_reqack  = ack_q | ((state == WR_DATA) & bus.bus_reqcyc);
    assign bus.bus_respcyc = (state == RD_RESP);
    assign bus.bus_resp    = (state == RD_RESP) ? mem[idx] : '0;
    assign bus.bus_resptag = (state == RD_RESP) ? tag : '0;
endmodule
